// File: rtl/bus_requester_pkg.sv
// Shared types for the snoopy-bus requester.
//   NUM_CPUS / LINE_BITS : system geometry
//   SRC_W                : width of the requester id on the bus
//   bus_cmd_t            : bus command encoding (2 bits)
//   bus_req_state_t      : requester FSM states
package types;

  localparam int NUM_CPUS  = 4;
  localparam int LINE_BITS = 64;
  localparam int SRC_W     = $clog2(NUM_CPUS);

  typedef enum logic [1:0] {
    BUS_RD   = 2'd0,
    BUS_RDX  = 2'd1,
    BUS_UPGR = 2'd2,
    BUS_WB   = 2'd3
  } bus_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_WAIT,
    ST_RESP
  } bus_req_state_t;

  // Only reads bring a line back; upgrades and writebacks complete with no data.
  function automatic logic cmd_returns_data(input bus_cmd_t c);
    return (c == BUS_RD) || (c == BUS_RDX);
  endfunction

endpackage

// File: rtl/bus_requester_timer.sv
// bus_req_timer: grant-wait watchdog. Counts cycles spent requesting
// without a grant and raises a sticky error once TIMEOUT_CYCLES is reached.
//   clk, rst : clock, sync active-high reset (the only way to clear o_err)
//   i_clr    : entering the request state, restart the count
//   i_inc    : requesting and not granted this cycle
//   o_err    : sticky timeout flag
module bus_req_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (i_clr)
        r_cnt <= '0;
      else if (i_inc && r_cnt != CW'(TIMEOUT_CYCLES))
        r_cnt <= r_cnt + 1'b1;
      // Flag rises in the same cycle the count lands on the limit.
      if (i_inc && r_cnt == CW'(TIMEOUT_CYCLES - 1))
        r_err <= 1'b1;
    end
  end

  assign o_err = r_err;

endmodule

// File: rtl/bus_requester.sv
// bus_requester: per-core initiator on the snoopy coherence bus.
// Takes one command from the L1, requests the arbiter, drives a one-cycle
// address phase on grant, waits for the responder and returns its line.
// Optional macro BUS_REQ_TIMEOUT_EN builds the grant-wait watchdog
// (bus_req_timer); without it timeout_err is tied low.
//   clk, rst            : clock, sync active-high reset
//   cpu_req_*           : command in from the cache (valid/ready/cmd/addr)
//   cpu_resp_*          : completion pulse, returned line, shared flag
//   arb_req / arb_gnt   : round-robin arbiter handshake
//   bus_valid/cmd/addr/src : address phase (cmd/addr zero when not valid)
//   bus_resp_*          : responder completion for this core
//   busy_out            : holds off arbiter grants ADDR..RESP
//   timeout_err         : sticky grant-timeout flag
module bus_requester
  import types::*;
#(
  parameter int CPU_ID         = 0,
  parameter int ADDR_BITS      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req_valid,
  output logic                 cpu_req_ready,
  input  bus_cmd_t             cpu_req_cmd,
  input  logic [ADDR_BITS-1:0] cpu_req_addr,
  output logic                 cpu_resp_valid,
  output logic [LINE_BITS-1:0] cpu_resp_data,
  output logic                 cpu_resp_shared,
  output logic                 arb_req,
  input  logic                 arb_gnt,
  output logic                 bus_valid,
  output bus_cmd_t             bus_cmd,
  output logic [ADDR_BITS-1:0] bus_addr,
  output logic [SRC_W-1:0]     bus_src,
  input  logic                 bus_resp_valid,
  input  logic [LINE_BITS-1:0] bus_resp_data,
  input  logic                 bus_resp_shared,
  output logic                 busy_out,
  output logic                 timeout_err
);

  bus_req_state_t       r_state, w_next;
  bus_cmd_t             r_cmd;
  logic [ADDR_BITS-1:0] r_addr;
  logic [LINE_BITS-1:0] r_data;
  logic                 r_shared;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cmd    <= BUS_RD;
      r_addr   <= '0;
      r_data   <= '0;
      r_shared <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && cpu_req_valid) begin
        r_cmd  <= cpu_req_cmd;
        r_addr <= cpu_req_addr;
      end
      if (r_state == ST_WAIT && bus_resp_valid) begin
        r_data   <= cmd_returns_data(r_cmd) ? bus_resp_data : '0;
        r_shared <= bus_resp_shared;
      end
      // Strays are ignored by the FSM but point at an arbiter/responder bug.
      assert (!arb_gnt || r_state == ST_REQ);
      assert (!bus_resp_valid || r_state == ST_WAIT);
      assert (TIMEOUT_CYCLES > 0);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (cpu_req_valid)  w_next = ST_REQ;
      ST_REQ:  if (arb_gnt)        w_next = ST_ADDR;
      ST_ADDR:                     w_next = ST_WAIT;
      ST_WAIT: if (bus_resp_valid) w_next = ST_RESP;
      ST_RESP:                     w_next = ST_IDLE;
      default:                     w_next = ST_IDLE;
    endcase
  end

  // Every control output is a pure decode of r_state, so nothing combinational
  // runs from arb_gnt (or any other input) to an output.
  always_comb begin
    cpu_req_ready  = (r_state == ST_IDLE);
    arb_req        = (r_state == ST_REQ);
    bus_valid      = (r_state == ST_ADDR);
    busy_out       = (r_state == ST_ADDR) || (r_state == ST_WAIT) || (r_state == ST_RESP);
    cpu_resp_valid = (r_state == ST_RESP);
    bus_cmd        = BUS_RD;
    bus_addr       = '0;
    if (r_state == ST_ADDR) begin
      bus_cmd  = r_cmd;
      bus_addr = r_addr;
    end
  end

  assign cpu_resp_data   = r_data;
  assign cpu_resp_shared = r_shared;
  assign bus_src         = SRC_W'(CPU_ID);

`ifdef BUS_REQ_TIMEOUT_EN
  logic w_to_clr, w_to_inc;
  assign w_to_clr = (r_state == ST_IDLE) && cpu_req_valid;
  assign w_to_inc = (r_state == ST_REQ) && !arb_gnt;

  bus_req_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_to_clr),
    .i_inc (w_to_inc),
    .o_err (timeout_err)
  );
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_requester.sv
// Self-checking bench for bus_requester. Each transaction is described by
// its grant delay and response delay; expected outputs per cycle follow from
// the published latencies (accept at 0, req from 1, address at 2+gd,
// completion at 4+gd+rd).
module tb_bus_requester;
  import types::*;

  localparam int TO = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cpu_req_valid = 1'b0;
  logic                 cpu_req_ready;
  bus_cmd_t             cpu_req_cmd = BUS_RD;
  logic [31:0]          cpu_req_addr = '0;
  logic                 cpu_resp_valid;
  logic [LINE_BITS-1:0] cpu_resp_data;
  logic                 cpu_resp_shared;
  logic                 arb_req;
  logic                 arb_gnt = 1'b0;
  logic                 bus_valid;
  bus_cmd_t             bus_cmd;
  logic [31:0]          bus_addr;
  logic [SRC_W-1:0]     bus_src;
  logic                 bus_resp_valid = 1'b0;
  logic [LINE_BITS-1:0] bus_resp_data = '0;
  logic                 bus_resp_shared = 1'b0;
  logic                 busy_out;
  logic                 timeout_err;

  bus_requester #(.CPU_ID(2), .ADDR_BITS(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_cmd(cpu_req_cmd), .cpu_req_addr(cpu_req_addr),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_data(cpu_resp_data),
    .cpu_resp_shared(cpu_resp_shared),
    .arb_req(arb_req), .arb_gnt(arb_gnt),
    .bus_valid(bus_valid), .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_src(bus_src),
    .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
    .bus_resp_shared(bus_resp_shared),
    .busy_out(busy_out), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: last delivered line/shared and the sticky timeout bit.
  logic [LINE_BITS-1:0] last_data = '0;
  logic                 last_sh   = 1'b0;
  logic                 exp_err   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all(input logic rdy, input logic req, input logic bv,
                         input logic [1:0] cmd, input logic [31:0] addr,
                         input logic busy, input logic rv);
    chk("ready",     64'(cpu_req_ready),   64'(rdy));
    chk("arb_req",   64'(arb_req),         64'(req));
    chk("bus_valid", 64'(bus_valid),       64'(bv));
    chk("bus_cmd",   64'(bus_cmd),         64'(cmd));
    chk("bus_addr",  64'(bus_addr),        64'(addr));
    chk("busy",      64'(busy_out),        64'(busy));
    chk("resp_vld",  64'(cpu_resp_valid),  64'(rv));
    chk("resp_data", 64'(cpu_resp_data),   64'(last_data));
    chk("resp_sh",   64'(cpu_resp_shared), 64'(last_sh));
    chk("bus_src",   64'(bus_src),         64'd2);
    chk("timeout",   64'(timeout_err),     64'(exp_err));
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      cpu_req_valid  = 1'b0;
      arb_gnt        = 1'b0;
      bus_resp_valid = 1'b0;
      @(negedge clk);
      chk_all(1, 0, 0, 2'd0, 32'd0, 0, 0);
    end
  endtask

  // One full transaction; noise toggles cpu_req_valid while busy (must be ignored).
  task automatic txn(input bus_cmd_t cmd, input logic [31:0] addr, input int gd,
                     input int rd, input logic [63:0] data, input logic sh, input bit noise);
    int fin;
    fin = 4 + gd + rd;
    cycle();
    cpu_req_valid = 1'b1; cpu_req_cmd = cmd; cpu_req_addr = addr;
    arb_gnt = 1'b0; bus_resp_valid = 1'b0;
    @(negedge clk);
    chk_all(1, 0, 0, 2'd0, 32'd0, 0, 0);
    for (int t = 1; t <= fin; t++) begin
      cycle();
      cpu_req_valid   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      cpu_req_cmd     = bus_cmd_t'(2'($urandom_range(0, 3)));
      cpu_req_addr    = $urandom;
      arb_gnt         = (t == 1 + gd);
      bus_resp_valid  = (t == 3 + gd + rd);
      bus_resp_data   = bus_resp_valid ? data : {$urandom, $urandom};
      bus_resp_shared = bus_resp_valid ? sh : 1'($urandom_range(0, 1));
`ifdef BUS_REQ_TIMEOUT_EN
      if (gd >= TO && t >= 1 + TO) exp_err = 1'b1;
`endif
      if (t == fin) begin
        last_data = (cmd == BUS_RD || cmd == BUS_RDX) ? data : 64'd0;
        last_sh   = sh;
      end
      @(negedge clk);
      chk_all(0, t <= 1 + gd, t == 2 + gd,
              (t == 2 + gd) ? 2'(cmd) : 2'd0, (t == 2 + gd) ? addr : 32'd0,
              t >= 2 + gd, t == fin);
    end
    cpu_req_valid = 1'b0; arb_gnt = 1'b0; bus_resp_valid = 1'b0;
  endtask

  // Reset lands while waiting for the responder: everything drops, no completion.
  task automatic reset_mid(input logic [31:0] addr);
    cycle();
    cpu_req_valid = 1'b1; cpu_req_cmd = BUS_RDX; cpu_req_addr = addr;
    @(negedge clk); chk_all(1, 0, 0, 2'd0, 32'd0, 0, 0);
    cycle(); cpu_req_valid = 1'b0; arb_gnt = 1'b1;
    @(negedge clk); chk_all(0, 1, 0, 2'd0, 32'd0, 0, 0);
    cycle(); arb_gnt = 1'b0;
    @(negedge clk); chk_all(0, 0, 1, 2'(BUS_RDX), addr, 1, 0);
    cycle();
    @(negedge clk); chk_all(0, 0, 0, 2'd0, 32'd0, 1, 0);
    rst = 1'b1;
    cycle(); rst = 1'b0;
    last_data = '0; last_sh = 1'b0; exp_err = 1'b0;
    @(negedge clk); chk_all(1, 0, 0, 2'd0, 32'd0, 0, 0);
    idle(3);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all(1, 0, 0, 2'd0, 32'd0, 0, 0);
    rst = 1'b0;
    idle(2);

    txn(BUS_RD,   32'h1000, 0, 0, {8{8'hA5}}, 1'b1, 1'b0);
    txn(BUS_RDX,  $urandom, 10, 2, {$urandom, $urandom}, 1'b0, 1'b1);
    txn(BUS_UPGR, $urandom, 1, 1, {64{1'b1}}, 1'b1, 1'b0);
    txn(BUS_WB,   $urandom, 0, 3, {64{1'b1}}, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      idle($urandom_range(0, 2));
      txn(bus_cmd_t'(2'($urandom_range(0, 3))), $urandom, $urandom_range(0, 5),
          $urandom_range(0, 4), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1);
    end

    reset_mid(32'hDEAD_BEE0);
    txn(BUS_RD, 32'h2040, TO, 0, {8{8'h3C}}, 1'b1, 1'b0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
